// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Grants a source, pulses tx_start/ack, waits for tx_done, then holds an idle gap.
module uart_tx_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REQ   = 4,
  parameter int IDLE_GAP  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           active
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t                 state;
  logic [IW-1:0]          rr_ptr;
  logic [GW-1:0]          gap_cnt;

  logic [DATA_BITS-1:0]   bytes [NUM_REQ];
  logic [IW-1:0]          idx;
  logic [IW-1:0]          pick;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic                   found;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      bytes[k] = req_data[k*DATA_BITS +: DATA_BITS];
    end
  end

  // Scan from rr_ptr upward, wrapping, and keep the first requesting source.
  always_comb begin
    idx         = '0;
    pick        = '0;
    pick_onehot = '0;
    found       = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found            = 1'b1;
        pick             = idx;
        pick_onehot[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gap_cnt  <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      owner    <= '0;
      active   <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!tx_busy && found) begin
            owner    <= pick;
            tx_data  <= bytes[pick];
            ack      <= pick_onehot;
            tx_start <= 1'b1;
            active   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state  <= SEND;
        end
        SEND: begin
          if (tx_done) begin
            if (IDLE_GAP > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              active <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            active <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
